fifo_reader: RTL and testbench

Read-side controller for the team's push/pop FIFO, which exposes only `data_out` and has no status flags. The block tracks FIFO occupancy from the push strobe and issues `pop` strobes itself. It presents each popped word on a registered valid/ready stream toward the downstream consumer. It sits between the FIFO's `data_out`/`pop` pins and any stream sink, and flags occupancy errors.

---
 rtl/fifo_reader_pkg.sv | 11 +
 rtl/fifo_reader.sv | 121 ++++++++++++
 tb/tb_fifo_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int RD_COUNT_W = 16;

endpackage : fifo_reader_pkg

// File: rtl/fifo_reader.sv
// Read-side controller for a flagless push/pop FIFO: tracks occupancy from the
// push strobe, issues pops, and presents each word on a registered valid/ready stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int FIFO_depth  = 8,
    parameter int FIFO_width  = 4,
    parameter int FIFO_cntr_w = 4
) (
    input  logic                   clk,
    input  logic                   FIFO_reset,
    input  logic                   push_mon,
    input  logic [FIFO_width-1:0]  fifo_data,
    output logic                   pop,
    output logic [FIFO_width-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [FIFO_cntr_w-1:0] level,
    output logic                   overflow,
    output logic [RD_COUNT_W-1:0]  rd_count
);

    localparam logic [FIFO_cntr_w-1:0] LEVEL_ZERO = {FIFO_cntr_w{1'b0}};
    localparam logic [FIFO_cntr_w-1:0] LEVEL_ONE  = {{(FIFO_cntr_w-1){1'b0}}, 1'b1};
    localparam logic [FIFO_cntr_w-1:0] LEVEL_FULL = FIFO_cntr_w'(FIFO_depth);
    localparam logic [RD_COUNT_W-1:0]  CNT_ZERO   = {RD_COUNT_W{1'b0}};
    localparam logic [RD_COUNT_W-1:0]  CNT_ONE    = {{(RD_COUNT_W-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [FIFO_cntr_w-1:0] r_level;
    logic [FIFO_cntr_w-1:0] w_level_next;
    logic [FIFO_width-1:0]  r_m_data;
    logic                   r_m_valid;
    logic                   r_overflow;
    logic [RD_COUNT_W-1:0]  r_rd_count;
    logic                   w_pop;
    logic                   w_accept;
    logic                   w_full;
    logic                   w_overflow_set;

    // Pop decision, next state, occupancy update and overflow detection.
    // pop uses the registered level, so it stays low while reset holds level at 0.
    always_comb begin
        w_state_next   = r_state;
        w_level_next   = r_level;
        w_full         = (r_level == LEVEL_FULL);
        w_accept       = (r_state == HOLD) && m_ready;
        w_pop          = (r_level != LEVEL_ZERO) && ((r_state == IDLE) || m_ready);
        w_overflow_set = push_mon && w_full && !w_pop;

        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                if (w_pop) begin
                    w_state_next = HOLD;
                end else if (m_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (push_mon && !w_pop) begin
            if (w_full) begin
                w_level_next = r_level;
            end else begin
                w_level_next = r_level + LEVEL_ONE;
            end
        end else if (w_pop && !push_mon) begin
            w_level_next = r_level - LEVEL_ONE;
        end else begin
            w_level_next = r_level;
        end
    end

    // State, stream register, occupancy and statistics registers.
    always_ff @(posedge clk or posedge FIFO_reset) begin
        if (FIFO_reset) begin
            r_state    <= IDLE;
            r_m_valid  <= 1'b0;
            r_m_data   <= {FIFO_width{1'b0}};
            r_level    <= LEVEL_ZERO;
            r_overflow <= 1'b0;
            r_rd_count <= CNT_ZERO;
        end else begin
            r_state    <= w_state_next;
            r_m_valid  <= (w_state_next == HOLD);
            r_level    <= w_level_next;
            r_overflow <= r_overflow | w_overflow_set;
            if (w_pop) begin
                r_m_data <= fifo_data;
            end else begin
                r_m_data <= r_m_data;
            end
            if (w_accept) begin
                r_rd_count <= r_rd_count + CNT_ONE;
            end else begin
                r_rd_count <= r_rd_count;
            end
        end
    end

    assign pop      = w_pop;
    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign rd_count = r_rd_count;

endmodule : fifo_reader

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural FIFO feeds the DUT, stimulus
// queues the expected words and a monitor checks each accepted stream beat.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          FIFO_reset;
    logic          push_mon;
    logic [W-1:0]  push_data;
    logic [W-1:0]  fifo_data;
    logic          pop;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] level;
    logic          overflow;
    logic [15:0]   rd_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0] mem [DEPTH];
    int wr_ptr, rd_ptr, cnt;
    logic w_do_push;

    always #5 clk = ~clk;

    fifo_reader #(.FIFO_depth(DEPTH), .FIFO_width(W), .FIFO_cntr_w(CW)) dut (
        .clk(clk), .FIFO_reset(FIFO_reset), .push_mon(push_mon), .fifo_data(fifo_data),
        .pop(pop), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .overflow(overflow), .rd_count(rd_count)
    );

    // Behavioural push/pop FIFO; a push into a full FIFO is dropped.
    assign w_do_push = push_mon && ((cnt < DEPTH) || pop);
    assign fifo_data = mem[rd_ptr];

    always @(posedge clk or posedge FIFO_reset) begin
        if (FIFO_reset) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
            cnt    <= 0;
        end else begin
            if (w_do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr + 1) % DEPTH;
            end
            if (pop) rd_ptr <= (rd_ptr + 1) % DEPTH;
            cnt <= cnt + (w_do_push ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // Monitor: every accepted beat must match the oldest queued word.
    always @(negedge clk) begin
        if (!FIFO_reset && m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL stream_beat: got data %0h, expected no beat", m_data);
            end else begin
                if (m_data !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL stream_beat: got data %0h, expected %0h", m_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        FIFO_reset = 1'b1;
        push_mon   = 1'b0;
        m_ready    = 1'b0;
        exp_q.delete();
        cyc();
        FIFO_reset = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v, input bit expect_out);
        push_mon  = 1'b1;
        push_data = v;
        if (expect_out) exp_q.push_back(v);
    endtask

    initial begin
        FIFO_reset = 1'b1;
        push_mon   = 1'b0;
        push_data  = 4'h0;
        m_ready    = 1'b0;
        cyc();
        #1;
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        cyc();
        FIFO_reset = 1'b0;

        // Single word
        m_ready = 1'b1;
        push(4'hA, 1'b1);
        #1 check("single_pop_c0", 32'(pop), 32'd0);
        cyc();
        push_mon = 1'b0;
        #1;
        check("single_pop_c1", 32'(pop), 32'd1);
        check("single_level_c1", 32'(level), 32'd1);
        cyc();
        #1;
        check("single_valid_c2", 32'(m_valid), 32'd1);
        check("single_data_c2", 32'(m_data), 32'hA);
        check("single_level_c2", 32'(level), 32'd0);
        cyc();
        #1;
        check("single_rd_count", 32'(rd_count), 32'd1);
        check("single_valid_c3", 32'(m_valid), 32'd0);

        // Streaming
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(4'(i + 1), 1'b1);
            #1;
            check("stream_level", 32'(level), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) check("stream_pop", 32'(pop), 32'd1);
            cyc();
        end
        push_mon = 1'b0;
        #1 check("stream_pop_last", 32'(pop), 32'd1);
        cyc();
        #1;
        check("stream_level_end", 32'(level), 32'd0);
        check("stream_valid_last", 32'(m_valid), 32'd1);
        check("stream_data_last", 32'(m_data), 32'h8);
        cyc();
        #1;
        check("stream_rd_count", 32'(rd_count), 32'd8);
        check("stream_valid_end", 32'(m_valid), 32'd0);

        // Backpressure
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(4'(11 + i), 1'b1);
            cyc();
        end
        push_mon = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_pop", 32'(pop), 32'd0);
            check("bp_level", 32'(level), 32'd2);
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), 32'hB);
            cyc();
        end
        m_ready = 1'b1;
        #1;
        check("bp_rel_pop0", 32'(pop), 32'd1);
        cyc();
        #1;
        check("bp_rel_pop1", 32'(pop), 32'd1);
        check("bp_rel_data1", 32'(m_data), 32'hC);
        check("bp_rel_level1", 32'(level), 32'd1);
        cyc();
        #1;
        check("bp_rel_pop2", 32'(pop), 32'd0);
        check("bp_rel_data2", 32'(m_data), 32'hD);
        check("bp_rel_valid2", 32'(m_valid), 32'd1);
        cyc();
        #1;
        check("bp_rd_count", 32'(rd_count), 32'd3);
        check("bp_valid_end", 32'(m_valid), 32'd0);

        // Overflow: the 10th push hits a full FIFO and is lost
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(4'(i), i < 9);
            #1;
            check("ovf_level", 32'(level), (i < 2) ? 32'(i) : 32'(i - 1));
            check("ovf_not_yet", 32'(overflow), 32'd0);
            cyc();
        end
        push_mon = 1'b0;
        #1;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level_sat", 32'(level), 32'd8);
        m_ready = 1'b1;
        repeat (12) cyc();
        #1;
        check("ovf_drain_level", 32'(level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_rd_count", 32'(rd_count), 32'd9);

        // Simultaneous push/pop at level 3
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(4'(i + 1), 1'b1);
            cyc();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(4'(i + 5), 1'b1);
            #1;
            check("sim_pop", 32'(pop), 32'd1);
            check("sim_level", 32'(level), 32'd3);
            cyc();
        end
        push_mon = 1'b0;
        repeat (6) cyc();
        #1;
        check("sim_level_end", 32'(level), 32'd0);
        check("sim_rd_count", 32'(rd_count), 32'd9);

        // Reset while a word is held
        m_ready = 1'b0;
        push(4'h7, 1'b0);
        cyc();
        push(4'h3, 1'b0);
        cyc();
        push_mon = 1'b0;
        #1 check("mid_hold_valid", 32'(m_valid), 32'd1);
        FIFO_reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_rd_count", 32'(rd_count), 32'd0);
        check("mid_rst_pop", 32'(pop), 32'd0);
        cyc();
        #1 check("mid_rst_pop_held", 32'(pop), 32'd0);
        FIFO_reset = 1'b0;
        cyc();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_reader
